// File: rtl/debug_pkg.sv
// Shared definitions for the debug frame serializer: ID width, header layout and FSM encoding.
package debug_pkg;

  localparam int unsigned ID_W          = 6;
  localparam int unsigned HDR_ID_LSB    = 0;
  localparam int unsigned HDR_BEATS_LSB = 8;
  localparam int unsigned HDR_BEATS_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } dbg_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/debug_request_detect.sv
// Request event detection (range + change edge), one-deep pending slot and overflow pulse.
module debug_request_detect
  import debug_pkg::*;
#(
  parameter logic [ID_W-1:0] BASE_ID    = '0,
  parameter int unsigned     N_CHANNELS = 4,
  parameter int unsigned     CH_W       = 2
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic [ID_W-1:0] i_request_select,
  input  logic            i_idle,
  input  logic            i_done,
  output logic            o_start_c,
  output logic [CH_W-1:0] o_start_ch_c,
  output logic            o_overflow
);

  localparam int unsigned RW = ID_W + 1;

  logic [ID_W-1:0] prev_select;
  logic            prev_in_range;
  logic            pend_valid;
  logic [CH_W-1:0] pend_ch;

  logic            in_range_c;
  logic            event_c;
  logic [CH_W-1:0] event_ch_c;
  logic            consume_c;
  logic            direct_c;
  logic            enqueue_c;

  // A finishing transfer hands over to the pending request first; a new event then refills the slot.
  always_comb begin
    in_range_c   = ({1'b0, i_request_select} >= RW'(BASE_ID)) &&
                   ({1'b0, i_request_select} <  (RW'(BASE_ID) + RW'(N_CHANNELS)));
    event_c      = in_range_c && (!prev_in_range || (i_request_select != prev_select));
    event_ch_c   = CH_W'(i_request_select - BASE_ID);
    consume_c    = i_done && pend_valid;
    direct_c     = event_c && (i_idle || (i_done && !pend_valid));
    enqueue_c    = event_c && !direct_c && (!pend_valid || consume_c);
    o_start_c    = direct_c || consume_c;
    o_start_ch_c = consume_c ? pend_ch : event_ch_c;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      prev_select   <= '0;
      prev_in_range <= 1'b0;
      pend_valid    <= 1'b0;
      pend_ch       <= '0;
      o_overflow    <= 1'b0;
    end else begin
      prev_select   <= i_request_select;
      prev_in_range <= in_range_c;
      o_overflow    <= event_c && !direct_c && pend_valid && !consume_c;
      if (enqueue_c) begin
        pend_valid <= 1'b1;
        pend_ch    <= event_ch_c;
      end else if (consume_c) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/debug_frame_serializer.sv
// Serializes one selected debug channel word into an optional header plus LSB-first data frames
// over a valid/ready interface.
module debug_frame_serializer
  import debug_pkg::*;
#(
  parameter int unsigned     NB_LATCH      = 32,
  parameter int unsigned     NB_INPUT_SIZE = 80,
  parameter int unsigned     N_CHANNELS    = 4,
  parameter logic [ID_W-1:0] BASE_ID       = 6'b000000,
  parameter bit              HEADER_EN     = 1'b1
) (
  input  logic                                i_clock,
  input  logic                                i_reset,
  input  logic [ID_W-1:0]                     i_request_select,
  input  logic [N_CHANNELS*NB_INPUT_SIZE-1:0] i_data_from_mips,
  input  logic                                i_ready,
  output logic [NB_LATCH-1:0]                 o_frame,
  output logic                                o_valid,
  output logic                                o_last,
  output logic                                o_busy,
  output logic                                o_overflow
);

  localparam int unsigned BEATS  = ceil_div(NB_INPUT_SIZE, NB_LATCH);
  localparam int unsigned PAD_W  = BEATS * NB_LATCH;
  localparam int unsigned BEAT_W = $clog2(BEATS + 1);
  localparam int unsigned CH_W   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  function automatic logic [NB_LATCH-1:0] chunk(input logic [PAD_W-1:0] pad,
                                                input logic [BEAT_W-1:0] idx);
    chunk = '0;
    for (int unsigned i = 0; i < BEATS; i++) begin
      if (idx == BEAT_W'(i)) chunk = pad[i*NB_LATCH +: NB_LATCH];
    end
  endfunction

  function automatic logic [NB_LATCH-1:0] header_frame(input logic [CH_W-1:0] ch);
    header_frame = '0;
    header_frame[HDR_ID_LSB +: ID_W]           = BASE_ID + ID_W'(ch);
    header_frame[HDR_BEATS_LSB +: HDR_BEATS_W] = HDR_BEATS_W'(BEATS);
  endfunction

  dbg_state_e          state_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [PAD_W-1:0]    data_q;

  logic                accept_c;
  logic                done_c;
  logic                idle_c;
  logic                start_c;
  logic [CH_W-1:0]     start_ch_c;
  logic [NB_INPUT_SIZE-1:0] start_word_c;
  logic [PAD_W-1:0]    start_pad_c;
  logic [BEAT_W-1:0]   beat_next_c;

  debug_request_detect #(
    .BASE_ID    (BASE_ID),
    .N_CHANNELS (N_CHANNELS),
    .CH_W       (CH_W)
  ) u_request_detect (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_request_select (i_request_select),
    .i_idle           (idle_c),
    .i_done           (done_c),
    .o_start_c        (start_c),
    .o_start_ch_c     (start_ch_c),
    .o_overflow       (o_overflow)
  );

  // Channel word is captured only when its transfer actually starts.
  always_comb begin
    idle_c       = (state_q == ST_IDLE);
    accept_c     = o_valid && i_ready;
    done_c       = accept_c && (state_q == ST_DATA) && (beat_q == LAST_BEAT);
    beat_next_c  = beat_q + BEAT_W'(1);
    start_word_c = '0;
    for (int unsigned k = 0; k < N_CHANNELS; k++) begin
      if (start_ch_c == CH_W'(k)) start_word_c = i_data_from_mips[k*NB_INPUT_SIZE +: NB_INPUT_SIZE];
    end
    start_pad_c  = PAD_W'(start_word_c);
  end

  // A start on the last-beat acceptance edge overrides the return to idle.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      data_q  <= '0;
      o_frame <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_busy  <= 1'b0;
    end else if (start_c) begin
      data_q  <= start_pad_c;
      beat_q  <= '0;
      o_valid <= 1'b1;
      o_busy  <= 1'b1;
      if (HEADER_EN) begin
        state_q <= ST_HEADER;
        o_frame <= header_frame(start_ch_c);
        o_last  <= 1'b0;
      end else begin
        state_q <= ST_DATA;
        o_frame <= chunk(start_pad_c, '0);
        o_last  <= (LAST_BEAT == '0);
      end
    end else if (accept_c) begin
      unique case (state_q)
        ST_HEADER: begin
          state_q <= ST_DATA;
          beat_q  <= '0;
          o_frame <= chunk(data_q, '0);
          o_last  <= (LAST_BEAT == '0);
        end
        ST_DATA: begin
          if (beat_q == LAST_BEAT) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            o_frame <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
          end else begin
            beat_q  <= beat_next_c;
            o_frame <= chunk(data_q, beat_next_c);
            o_last  <= (beat_next_c == LAST_BEAT);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          o_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_serializer.sv
// Bench for debug_frame_serializer: transaction-level frame queue model plus directed literal checks.
module tb_debug_frame_serializer;

  localparam int NL    = 32;
  localparam int NI    = 80;
  localparam int NC    = 4;
  localparam int BASE  = 0;
  localparam int BEATS = (NI + NL - 1) / NL;

  logic              i_clock = 1'b0;
  logic              i_reset;
  logic [5:0]        i_request_select;
  logic [NC*NI-1:0]  i_data_from_mips;
  logic              i_ready;
  logic [NL-1:0]     o_frame;
  logic              o_valid;
  logic              o_last;
  logic              o_busy;
  logic              o_overflow;

  always #5 i_clock = ~i_clock;

  debug_frame_serializer #(
    .NB_LATCH      (NL),
    .NB_INPUT_SIZE (NI),
    .N_CHANNELS    (NC),
    .BASE_ID       (6'b000000),
    .HEADER_EN     (1'b1)
  ) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .i_request_select (i_request_select),
    .i_data_from_mips (i_data_from_mips),
    .i_ready          (i_ready),
    .o_frame          (o_frame),
    .o_valid          (o_valid),
    .o_last           (o_last),
    .o_busy           (o_busy),
    .o_overflow       (o_overflow)
  );

  typedef struct packed {logic [NL-1:0] f; logic l;} frm_t;
  typedef struct {logic [NL-1:0] f; logic l; int c;} log_t;

  frm_t       mq[$];
  log_t       acc_log[$];
  logic       m_pv;
  int         m_pc;
  logic       m_prev_in;
  logic [5:0] m_prev_sel;
  logic       m_ovf;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;
  int ovf_count = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Queue every frame a transfer of channel ch must produce, data sampled now.
  function automatic void build(input int ch);
    logic [NC*NI-1:0]    bus;
    logic [BEATS*NL-1:0] pad;
    logic [BEATS*NL-1:0] sh;
    bus = i_data_from_mips >> (ch * NI);
    pad = '0;
    pad[NI-1:0] = bus[NI-1:0];
    mq.push_back('{f: NL'((BEATS << 8) | (BASE + ch)), l: 1'b0});
    for (int i = 0; i < BEATS; i++) begin
      sh = pad >> (NL * i);
      mq.push_back('{f: sh[NL-1:0], l: (i == BEATS - 1)});
    end
  endfunction

  // Reference model: advance one clock edge using the inputs seen at that edge.
  always @(posedge i_clock) begin
    bit in_r;
    bit ev;
    bit busy0;
    cyc_n++;
    if (i_reset) begin
      mq.delete();
      m_pv       = 1'b0;
      m_pc       = 0;
      m_prev_in  = 1'b0;
      m_prev_sel = '0;
      m_ovf      = 1'b0;
    end else begin
      in_r  = (int'(i_request_select) >= BASE) && (int'(i_request_select) < BASE + NC);
      ev    = in_r && (!m_prev_in || (i_request_select != m_prev_sel));
      m_ovf = 1'b0;
      busy0 = (mq.size() != 0);
      if (busy0 && i_ready) void'(mq.pop_front());
      if (busy0 && mq.size() == 0 && m_pv) begin
        build(m_pc);
        m_pv = 1'b0;
      end
      if (ev) begin
        if (mq.size() == 0) build(int'(i_request_select) - BASE);
        else if (!m_pv) begin
          m_pv = 1'b1;
          m_pc = int'(i_request_select) - BASE;
        end else m_ovf = 1'b1;
      end
      m_prev_in  = in_r;
      m_prev_sel = i_request_select;
    end
  end

  // Compare process plus acceptance log.
  always @(negedge i_clock) begin
    if (started) begin
      check("valid", o_valid, mq.size() != 0);
      check("busy", o_busy, mq.size() != 0);
      check("overflow", o_overflow, m_ovf);
      if (mq.size() != 0) begin
        check("frame", o_frame, mq[0].f);
        check("last", o_last, mq[0].l);
      end
      if (o_valid && i_ready) acc_log.push_back('{f: o_frame, l: o_last, c: cyc_n});
      if (o_overflow) ovf_count++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic rand_mips();
    i_data_from_mips = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(),
                        $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic expect_log(input string nm, input int idx, input logic [NL-1:0] f, input logic l);
    if (idx < acc_log.size()) begin
      check(nm, acc_log[idx].f, f);
      check({nm, "_last"}, acc_log[idx].l, l);
    end
  endtask

  initial begin
    i_reset          = 1'b1;
    i_request_select = 6'h3F;
    i_ready          = 1'b1;
    rand_mips();
    @(posedge i_clock);
    #1;
    started = 1'b1;
    cyc(1);
    check("rst_valid", o_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_last", o_last, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_frame", o_frame, 0);
    i_reset = 1'b0;

    // Basic transfer of channel 2.
    acc_log.delete();
    i_data_from_mips[2*NI +: NI] = 80'h1234_89ABCDEF_01234567;
    i_request_select = 6'd2;
    cyc(10);
    check("t1_count", acc_log.size(), 4);
    expect_log("t1_hdr", 0, 32'h0000_0302, 1'b0);
    expect_log("t1_b0", 1, 32'h0123_4567, 1'b0);
    expect_log("t1_b1", 2, 32'h89AB_CDEF, 1'b0);
    expect_log("t1_b2", 3, 32'h0000_1234, 1'b1);
    check("t1_busy_after", o_busy, 0);

    // Back-pressure on beat 0 for five cycles.
    i_request_select = 6'h3F;
    cyc(1);
    acc_log.delete();
    i_data_from_mips[1*NI +: NI] = 80'hAAAA_BBBBBBBB_CCCCCCCC;
    i_request_select = 6'd1;
    cyc(2);
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      check("t2_hold_frame", o_frame, 32'hCCCC_CCCC);
      check("t2_hold_valid", o_valid, 1);
    end
    i_ready = 1'b1;
    cyc(6);
    check("t2_count", acc_log.size(), 4);
    expect_log("t2_hdr", 0, 32'h0000_0301, 1'b0);
    expect_log("t2_b0", 1, 32'hCCCC_CCCC, 1'b0);
    expect_log("t2_b1", 2, 32'hBBBB_BBBB, 1'b0);
    expect_log("t2_b2", 3, 32'h0000_AAAA, 1'b1);

    // Queued request follows back-to-back.
    i_request_select = 6'h3F;
    cyc(1);
    acc_log.delete();
    rand_mips();
    i_request_select = 6'd1;
    cyc(2);
    i_request_select = 6'd3;
    cyc(12);
    check("t3_count", acc_log.size(), 8);
    if (acc_log.size() >= 5) begin
      check("t3_ch1_hdr", acc_log[0].f, 32'h0000_0301);
      check("t3_ch1_last", acc_log[3].l, 1);
      check("t3_ch3_hdr", acc_log[4].f, 32'h0000_0303);
      check("t3_no_gap", acc_log[4].c, acc_log[3].c + 1);
    end

    // Pending slot full: second request while busy is dropped.
    i_request_select = 6'h3F;
    cyc(1);
    acc_log.delete();
    ovf_count = 0;
    i_ready = 1'b0;
    i_request_select = 6'd0;
    cyc(2);
    i_request_select = 6'd1;
    cyc(1);
    i_request_select = 6'd3;
    cyc(2);
    check("t4_ovf_pulses", ovf_count, 1);
    i_ready = 1'b1;
    cyc(12);
    check("t4_count", acc_log.size(), 8);
    if (acc_log.size() >= 5) begin
      check("t4_ch0_hdr", acc_log[0].f, 32'h0000_0300);
      check("t4_ch1_hdr", acc_log[4].f, 32'h0000_0301);
    end
    check("t4_ovf_total", ovf_count, 1);

    // Held select gives one transfer; out-of-range select gives none.
    i_request_select = 6'h3F;
    cyc(1);
    acc_log.delete();
    i_request_select = 6'd2;
    cyc(20);
    check("t5_held_count", acc_log.size(), 4);
    acc_log.delete();
    i_request_select = 6'd7;
    cyc(8);
    check("t5_oor_count", acc_log.size(), 0);
    check("t5_oor_busy", o_busy, 0);

    // Reset in the middle of a transfer, then restart.
    i_request_select = 6'h3F;
    cyc(1);
    i_data_from_mips[2*NI +: NI] = 80'h1234_89ABCDEF_01234567;
    i_request_select = 6'd2;
    cyc(3);
    check("t6_on_beat1", o_frame, 32'h89AB_CDEF);
    i_reset = 1'b1;
    cyc(1);
    check("t6_rst_valid", o_valid, 0);
    check("t6_rst_busy", o_busy, 0);
    check("t6_rst_frame", o_frame, 0);
    i_reset = 1'b0;
    acc_log.delete();
    cyc(8);
    check("t6_count", acc_log.size(), 4);
    expect_log("t6_hdr", 0, 32'h0000_0302, 1'b0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) i_request_select = 6'($urandom_range(0, 9));
      i_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) rand_mips();
      i_reset = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    i_reset = 1'b0;
    i_ready = 1'b1;
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
